// File: rtl/shift_align_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : shift_align_seq
// Description : Sequential mantissa-alignment shifter using one shared 2:1 mux
//               row stepped through shifts of 8, 4, 2, 1. Optional sticky
//               output enabled by the SHIFT_STICKY_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_align_seq #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] in_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out_data,
    output logic             sticky
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S8   = 3'd1,
        ST_S4   = 3'd2,
        ST_S2   = 3'd3,
        ST_S1   = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q;
    logic [AMT_W-1:0]   amt_q;
    logic               dir_q;
    logic [WIDTH-1:0]   out_q;

    logic [4:0]         w_step_k;
    logic               w_step_sel;
    logic [WIDTH-1:0]   w_shifted;
    logic [WIDTH-1:0]   w_mux;

    // Each shift state selects its step size and the matching amount bit.
    always_comb begin
        state_d    = state_q;
        w_step_k   = 5'd0;
        w_step_sel = 1'b0;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_S8;
            ST_S8: begin
                state_d    = ST_S4;
                w_step_k   = 5'd8;
                w_step_sel = amt_q[3];
            end
            ST_S4: begin
                state_d    = ST_S2;
                w_step_k   = 5'd4;
                w_step_sel = amt_q[2];
            end
            ST_S2: begin
                state_d    = ST_S1;
                w_step_k   = 5'd2;
                w_step_sel = amt_q[1];
            end
            ST_S1: begin
                state_d    = ST_DONE;
                w_step_k   = 5'd1;
                w_step_sel = amt_q[0];
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign w_shifted = dir_q ? (data_q << w_step_k) : (data_q >> w_step_k);
    assign w_mux     = w_step_sel ? w_shifted : data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            amt_q   <= '0;
            dir_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        data_q <= in_data;
                        amt_q  <= amt;
                        dir_q  <= dir;
                    end
                end
                ST_S8, ST_S4, ST_S2: data_q <= w_mux;
                ST_S1: begin
                    data_q <= w_mux;
                    out_q  <= w_mux;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign out_data = out_q;

`ifdef SHIFT_STICKY_EN
    logic             sticky_acc_q;
    logic             sticky_q;
    logic [WIDTH-1:0] w_lost_mask;
    logic             w_lost;

    // Bits falling off the LSB end only matter on right shifts that are taken.
    assign w_lost_mask = (WIDTH'(1) << w_step_k) - WIDTH'(1);
    assign w_lost      = w_step_sel & ~dir_q & (|(data_q & w_lost_mask));

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_acc_q <= 1'b0;
            sticky_q     <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && start)
                sticky_acc_q <= 1'b0;
            else
                sticky_acc_q <= sticky_acc_q | w_lost;
            if (state_q == ST_S1)
                sticky_q <= sticky_acc_q | w_lost;
        end
    end

    assign sticky = sticky_q;
`else
    assign sticky = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_align_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_shift_align_seq
// Description : Directed self-checking bench for shift_align_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_align_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        dir;
    logic [3:0]  amt;
    logic [15:0] in_data;
    logic        busy;
    logic        done;
    logic [15:0] out_data;
    logic        sticky;

    int checks   = 0;
    int failures = 0;

`ifdef SHIFT_STICKY_EN
    localparam logic STICKY_ON = 1'b1;
`else
    localparam logic STICKY_ON = 1'b0;
`endif

    shift_align_seq #(.WIDTH(16), .AMT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dir      (dir),
        .amt      (amt),
        .in_data  (in_data),
        .busy     (busy),
        .done     (done),
        .out_data (out_data),
        .sticky   (sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, wait for done (bounded), check latency/result/stability.
    task automatic run_op(input string tag, input logic [15:0] d, input logic [3:0] a,
                          input logic dr, input logic [15:0] exp_out, input logic exp_st);
        int n;
        int bcnt;
        logic [15:0] prev;
        logic moved;
        prev    = out_data;
        moved   = 1'b0;
        in_data = d;
        amt     = a;
        dir     = dr;
        start   = 1'b1;
        step();
        start   = 1'b0;
        in_data = ~d;
        amt     = ~a;
        dir     = ~dr;
        n       = 0;
        bcnt    = 0;
        while (!done && n < 20) begin
            if (busy) bcnt++;
            if (out_data !== prev) moved = 1'b1;
            step();
            n++;
        end
        if (busy) bcnt++;
        chk({tag, "_latency"}, n, 4);
        chk({tag, "_busy_cycles"}, bcnt, 5);
        chk({tag, "_no_mid_update"}, moved, 0);
        chk({tag, "_out"}, out_data, exp_out);
        chk({tag, "_sticky"}, sticky, exp_st);
        step();
        chk({tag, "_done_single"}, {busy, done}, 2'b00);
    endtask

    initial begin
        int dcount;
        rst     = 1'b1;
        start   = 1'b0;
        dir     = 1'b0;
        amt     = 4'd0;
        in_data = 16'h0000;
        step();
        step();
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_out", out_data, 16'h0000);
        chk("reset_sticky", sticky, 0);
        rst = 1'b0;
        step();

        run_op("r8000_a4",  16'h8000, 4'd4,  1'b0, 16'h0800, 1'b0);
        run_op("r00FF_a9",  16'h00FF, 4'd9,  1'b0, 16'h0000, STICKY_ON);
        run_op("rFF00_a8",  16'hFF00, 4'd8,  1'b0, 16'h00FF, 1'b0);
        run_op("l0001_a15", 16'h0001, 4'd15, 1'b1, 16'h8000, 1'b0);
        run_op("A5A5_a0",   16'hA5A5, 4'd0,  1'b0, 16'hA5A5, 1'b0);
        run_op("r0003_a1",  16'h0003, 4'd1,  1'b0, 16'h0001, STICKY_ON);

        // Start held high: second op only accepted in IDLE after DONE.
        in_data = 16'h1234;
        amt     = 4'd1;
        dir     = 1'b0;
        start   = 1'b1;
        step();                                  // E0 accept
        chk("hold_busy_e0", busy, 1);
        in_data = 16'hFFFF;
        step(); step(); step();                  // E1..E3
        chk("hold_nodone_e3", done, 0);
        step();                                  // E4
        chk("hold_done_e4", done, 1);
        chk("hold_out_first", out_data, 16'h091A);
        step();                                  // E5 DONE->IDLE, start ignored
        chk("hold_idle_e5", {busy, done}, 2'b00);
        step();                                  // E6 second accept
        chk("hold_busy_e6", busy, 1);
        step(); step(); step();                  // E7..E9
        start = 1'b0;
        step();                                  // E10
        chk("hold_done_e10", done, 1);
        chk("hold_out_second", out_data, 16'h7FFF);
        step();

        // Reset mid-sequence while in S2.
        in_data = 16'h00F0;
        amt     = 4'd3;
        dir     = 1'b0;
        start   = 1'b1;
        step();                                  // -> S8
        start   = 1'b0;
        step();                                  // -> S4
        step();                                  // -> S2
        chk("abort_busy_pre", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_out", out_data, 16'h0000);
        chk("abort_sticky", sticky, 0);
        dcount = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) dcount++;
            step();
        end
        chk("abort_no_done", dcount, 0);

        run_op("post_abort", 16'h0010, 4'd4, 1'b0, 16'h0001, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_align_seq.md
# shift_align_seq

Sequential mantissa-alignment shifter controller for the FloatAdd datapath. It accepts a 16-bit operand and a 4-bit shift amount, then drives a single shared 16-bit 2:1 mux stage once per cycle through the binary-weighted shift steps 8, 4, 2, 1. It returns the shifted result with a one-cycle done pulse. It sits between the exponent-difference logic and the mantissa adder, replacing a four-level combinational barrel shifter with one mux row plus an FSM.

## Interface
- WIDTH, 16: datapath width. Fixed to 16 to match the shared mux row; other values unsupported.
- AMT_W, 4: shift-amount width. Legal amounts are 0..15.
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- dir  in  1  0 = logical right shift, 1 = logical left shift; sampled with start
- amt  in  4  shift amount; sampled with start
- in_data  in  16  operand; sampled with start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; out_data valid and stable from this cycle on
- out_data  out  16  result register; holds the last result until the next operation completes
- sticky  out  1  OR of all bits shifted out on a right shift (only with SHIFT_STICKY_EN; otherwise constant 0)

## Operation
- The FSM has six states: IDLE, S8, S4, S2, S1, DONE. Encoding is free.
- **IDLE**, start=1:
  - load data_reg←in_data, amt_reg←amt, dir_reg←dir; clear the sticky accumulator.
  - go to S8.
- **IDLE**, start=0: stay in IDLE.
- **Sk (k = 8, 4, 2, 1)**:
  - mux sel = amt_reg bit log2(k). i1 = data_reg shifted by k in direction dir_reg, zero-filled; i0 = data_reg.
  - data_reg←mux output.
  - next state: S8→S4→S2→S1.
- **S1 edge**: also loads out_data←final mux output; state→DONE.
- **DONE**: done=1 for exactly one cycle; unconditional return to IDLE.
- start is ignored in every state except IDLE, including DONE; no queueing.
- amt=0 still takes the full sequence, every step selects i0, and out_data=in_data.
- Shifts are logical only: no sign extension, no rotation, no wrap-around.
- Reset, from any state including mid-sequence:
  - state→IDLE; busy=0, done=0, out_data=16'h0000, sticky=0.
  - data_reg, amt_reg and dir_reg are cleared.
  - the aborted operation produces no done pulse.

## Timing
- Start accepted at edge E0. S8..S1 occupy cycles E0..E4. DONE (done=1) lies between E4 and E5. IDLE follows E5.
- Latency from start edge to done-high is 4 cycles after acceptance. Start-to-start throughput is 6 cycles minimum, since start is re-sampled in IDLE after DONE.
- busy rises the cycle after the accepting edge and falls with the exit from DONE.
- out_data and sticky change only on the S1→DONE edge or on reset. They are never mid-sequence values.
- in_data, amt and dir may change freely while busy.

## Configuration
- Macro: SHIFT_STICKY_EN.
- Defined:
  - in each S state with dir_reg=0 and sel=1, sticky_acc |= OR of the k LSBs of data_reg that are discarded.
  - sticky←sticky_acc on the S1 edge, together with out_data.
  - on left shifts sticky is 0.
- Undefined: no accumulator logic exists; the sticky port is tied to 0.

## Test plan
- in_data=16'h8000, amt=4, dir=0, pulse start -> done exactly once, 5 edges after start; out_data=16'h0800; sticky=0; busy high 5 cycles.
- in_data=16'h00FF, amt=9, dir=0 -> out_data=16'h0000; sticky=1 with SHIFT_STICKY_EN and 0 without. Repeat with 16'hFF00, amt=8: out_data=16'h00FF, sticky=0.
- in_data=16'h0001, amt=15, dir=1 -> out_data=16'h8000, sticky=0. Then amt=0, in_data=16'hA5A5 -> out_data=16'hA5A5 after the full 5-cycle sequence.
- Start held high for 10 cycles, in_data=16'h1234, amt=1, dir=0 -> first operation gives out_data=16'h091A. The second is accepted only in IDLE after DONE; a mid-busy change of in_data to 16'hFFFF does not affect the first result.
- Operation started with amt=3, rst asserted in S2 for one cycle -> next cycle busy=0, done=0, out_data=16'h0000, and no done pulse follows. A new start with 16'h0010, amt=4, dir=0 then gives 16'h0001.
